rmt_egress_pkt_buffer: RTL and testbench

- Store-and-forward egress buffer that sits directly downstream of the RMT pipeline deparser output (m_axis_* of the RMT top level) and upstream of the MAC TX interface.
- Accepts AXI-Stream beats unconditionally. A packet is released to the master side only after its tlast beat has been stored, so the MAC never sees an underrun mid-packet.
- A packet that does not fit in the buffer is dropped whole and counted.
- Decouples MAC backpressure from the deparser.

---
 rtl/rmt_egress_pkt_buffer.sv | 130 +++++++++++++
 tb/tb_rmt_egress_pkt_buffer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_egress_pkt_buffer.sv
// Store-and-forward egress buffer between the RMT deparser and the MAC TX port.
// Packets are released only once their tlast beat is stored; overflowing packets are dropped whole.
module rmt_egress_pkt_buffer #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int ADDR_WIDTH           = 9,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [CNT_WIDTH-1:0]              pkt_in_cnt,
    output logic [CNT_WIDTH-1:0]              pkt_drop_cnt,
    output logic [CNT_WIDTH-1:0]              pkt_out_cnt,
    output logic [ADDR_WIDTH:0]               buf_level
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int WORD_W = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH + KEEP_W + 1;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  commit_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [ADDR_WIDTH-1:0]  fetch_ptr;
    logic [ADDR_WIDTH-1:0]  wr_next;
    logic [WORD_W-1:0]      mem [2**ADDR_WIDTH];
    logic [WORD_W-1:0]      rd_word;
    logic                   accept;
    logic                   full;
    logic                   wr_en;
    logic                   out_fire;
    logic                   fetch_en;

    assign s_axis_tready = ~rst;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign wr_next       = wr_ptr + ADDR_WIDTH'(1);
    // rd_ptr only advances on egress handshake, so the beat held in the
    // output register still occupies its RAM slot and counts toward full.
    assign full          = (wr_next == rd_ptr);
    assign wr_en         = accept & (state != DROP) & ~full;
    assign out_fire      = m_axis_tvalid & m_axis_tready;
    assign fetch_en      = (fetch_ptr != commit_ptr) & (~m_axis_tvalid | m_axis_tready);
    assign rd_word       = mem[fetch_ptr];
    assign buf_level     = {1'b0, wr_ptr - rd_ptr};

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            pkt_in_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else if (accept) begin
            case (state)
                IDLE, RECV: begin
                    if (!full) begin
                        wr_ptr <= wr_next;
                        if (s_axis_tlast) begin
                            commit_ptr <= wr_next;
                            pkt_in_cnt <= pkt_in_cnt + CNT_WIDTH'(1);
                            state      <= IDLE;
                        end else begin
                            state <= RECV;
                        end
                    end else begin
                        wr_ptr <= commit_ptr;
                        if (s_axis_tlast) begin
                            pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);
                            state        <= IDLE;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                default: begin
                    if (s_axis_tlast) begin
                        pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);
                        state        <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr        <= '0;
            fetch_ptr     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            pkt_out_cnt   <= '0;
        end else begin
            if (out_fire) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                if (m_axis_tlast)
                    pkt_out_cnt <= pkt_out_cnt + CNT_WIDTH'(1);
            end
            if (fetch_en) begin
                {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast} <= rd_word;
                m_axis_tvalid <= 1'b1;
                fetch_ptr     <= fetch_ptr + ADDR_WIDTH'(1);
            end else if (out_fire) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rmt_egress_pkt_buffer.sv
// Scoreboard bench for rmt_egress_pkt_buffer with a 16-entry buffer and narrowed data/tuser widths.
module tb_rmt_egress_pkt_buffer;

    localparam int DW = 64;
    localparam int UW = 16;
    localparam int KW = DW / 8;
    localparam int AW = 4;
    localparam int CW = 32;
    localparam int WW = DW + UW + KW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [CW-1:0] pkt_in_cnt;
    logic [CW-1:0] pkt_drop_cnt;
    logic [CW-1:0] pkt_out_cnt;
    logic [AW:0]   buf_level;

    rmt_egress_pkt_buffer #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .ADDR_WIDTH          (AW),
        .CNT_WIDTH           (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .pkt_in_cnt   (pkt_in_cnt),
        .pkt_drop_cnt (pkt_drop_cnt),
        .pkt_out_cnt  (pkt_out_cnt),
        .buf_level    (buf_level)
    );

    always #5 clk = ~clk;

    logic [WW-1:0] sb[$];
    logic [WW-1:0] out_word;
    logic [WW-1:0] prev_word;
    logic [WW-1:0] exp_word;
    int            n_checks  = 0;
    int            n_pass    = 0;
    int            beats_out = 0;
    bit            prev_stall = 1'b0;

    assign out_word = {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast};

    // Egress monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (m_axis_tvalid !== 1'b1 || out_word !== prev_word)
                    $display("FAIL hold_stable: got valid=%b word=%h, required valid=1 word=%h",
                             m_axis_tvalid, out_word, prev_word);
                else
                    n_pass++;
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                n_checks++;
                beats_out++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_beat: got %h, required no beat (scoreboard empty)", out_word);
                end else begin
                    exp_word = sb.pop_front();
                    if (out_word !== exp_word)
                        $display("FAIL sb_beat: got %h, required %h", out_word, exp_word);
                    else
                        n_pass++;
                end
            end
            prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
            prev_word  = out_word;
        end
    end

    task automatic send_pkt(input int len, input bit push);
        for (int i = 0; i < len; i++) begin
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tuser  = UW'($urandom);
            s_axis_tkeep  = KW'($urandom);
            s_axis_tlast  = (i == len - 1);
            s_axis_tvalid = 1'b1;
            if (push)
                sb.push_back({s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast});
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && m_axis_tvalid !== 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (s_axis_tready !== 1'b0) $display("FAIL reset_tready: got %b, required 0", s_axis_tready);
        else n_pass++;
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tuser} !== '0)
            $display("FAIL reset_outputs: got valid=%b last=%b data=%h, required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        else n_pass++;
        n_checks++;
        if (pkt_in_cnt !== 0 || pkt_drop_cnt !== 0 || pkt_out_cnt !== 0 || buf_level !== 0)
            $display("FAIL reset_counters: got in=%0d drop=%0d out=%0d level=%0d, required 0 0 0 0",
                     pkt_in_cnt, pkt_drop_cnt, pkt_out_cnt, buf_level);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (s_axis_tready !== 1'b1) $display("FAIL post_reset_tready: got %b, required 1", s_axis_tready);
        else n_pass++;
    endtask

    task automatic test_latency();
        bit ok;
        m_axis_tready = 1'b1;
        send_pkt(3, 1'b1);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL latency_early: got tvalid=%b, required 0", m_axis_tvalid);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b1) $display("FAIL latency_n2: got tvalid=%b, required 1", m_axis_tvalid);
        else n_pass++;
        wait_drain(50, ok);
        n_checks++;
        if (!ok) $display("FAIL latency_drain: got timeout, required drained");
        else n_pass++;
        n_checks++;
        if (pkt_in_cnt !== 1 || pkt_out_cnt !== 1 || buf_level !== 0)
            $display("FAIL latency_counts: got in=%0d out=%0d level=%0d, required 1 1 0",
                     pkt_in_cnt, pkt_out_cnt, buf_level);
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit ok;
        int b0;
        m_axis_tready = 1'b0;
        send_pkt(10, 1'b1);
        send_pkt(8, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pkt_drop_cnt !== 1 || pkt_in_cnt !== 2)
            $display("FAIL overflow_counts: got drop=%0d in=%0d, required 1 2", pkt_drop_cnt, pkt_in_cnt);
        else n_pass++;
        n_checks++;
        if (buf_level !== 10) $display("FAIL overflow_level: got %0d, required 10", buf_level);
        else n_pass++;
        b0 = beats_out;
        m_axis_tready = 1'b1;
        wait_drain(100, ok);
        n_checks++;
        if (!ok || beats_out - b0 !== 10)
            $display("FAIL overflow_drain: got ok=%b beats=%0d, required ok=1 beats=10", ok, beats_out - b0);
        else n_pass++;
        n_checks++;
        if (pkt_out_cnt !== 2 || buf_level !== 0)
            $display("FAIL overflow_after: got out=%0d level=%0d, required 2 0", pkt_out_cnt, buf_level);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int gaps = 0;
        bit seen = 1'b0;
        logic [CW-1:0] out0, drop0;
        out0  = pkt_out_cnt;
        drop0 = pkt_drop_cnt;
        m_axis_tready = 1'b1;
        fork
            for (int p = 0; p < 40; p++) send_pkt(1, 1'b1);
            begin
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = (m_axis_tvalid === 1'b1);
                end
                repeat (39) begin
                    @(negedge clk);
                    if (m_axis_tvalid !== 1'b1) gaps++;
                end
            end
        join
        wait_drain(100, ok);
        n_checks++;
        if (!seen || gaps != 0)
            $display("FAIL b2b_gaps: got seen=%b gaps=%0d, required seen=1 gaps=0", seen, gaps);
        else n_pass++;
        n_checks++;
        if (!ok || pkt_out_cnt - out0 !== 40 || pkt_drop_cnt !== drop0)
            $display("FAIL b2b_counts: got ok=%b out_delta=%0d drop=%0d, required ok=1 40 %0d",
                     ok, pkt_out_cnt - out0, pkt_drop_cnt, drop0);
        else n_pass++;
    endtask

    task automatic test_random_ready();
        bit ok;
        bit done = 1'b0;
        int sent = 0;
        int b0;
        logic [CW-1:0] out0, drop0;
        out0  = pkt_out_cnt;
        drop0 = pkt_drop_cnt;
        b0    = beats_out;
        fork
            begin
                for (int p = 0; p < 20; p++) begin
                    int len;
                    int t;
                    len = int'($urandom_range(1, 7));
                    t = 0;
                    while (buf_level >= 8 && t < 200) begin
                        @(posedge clk);
                        #1;
                        t++;
                    end
                    if (t >= 200) begin
                        n_checks++;
                        $display("FAIL rand_space: got level=%0d after 200 cycles, required < 8", buf_level);
                    end
                    send_pkt(len, 1'b1);
                    sent += len;
                    repeat (int'($urandom_range(0, 2))) @(posedge clk);
                    #1;
                end
                done = 1'b1;
            end
            while (!done) begin
                m_axis_tready = $urandom_range(0, 1) == 1;
                @(posedge clk);
                #1;
            end
        join
        m_axis_tready = 1'b1;
        wait_drain(200, ok);
        n_checks++;
        if (!ok || beats_out - b0 != sent)
            $display("FAIL rand_drain: got ok=%b beats=%0d, required ok=1 beats=%0d", ok, beats_out - b0, sent);
        else n_pass++;
        n_checks++;
        if (pkt_out_cnt - out0 !== 20 || pkt_drop_cnt !== drop0)
            $display("FAIL rand_counts: got out_delta=%0d drop=%0d, required 20 %0d",
                     pkt_out_cnt - out0, pkt_drop_cnt, drop0);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [CW-1:0] in0, out0, drop0;
        in0   = pkt_in_cnt;
        out0  = pkt_out_cnt;
        drop0 = pkt_drop_cnt;
        m_axis_tready = 1'b1;
        for (int p = 0; p < 100; p++) send_pkt(5, 1'b1);
        wait_drain(200, ok);
        n_checks++;
        if (!ok || pkt_in_cnt - in0 !== 100 || pkt_out_cnt - out0 !== 100)
            $display("FAIL wrap_counts: got ok=%b in_delta=%0d out_delta=%0d, required ok=1 100 100",
                     ok, pkt_in_cnt - in0, pkt_out_cnt - out0);
        else n_pass++;
        n_checks++;
        if (pkt_drop_cnt !== drop0 || buf_level !== 0)
            $display("FAIL wrap_drop_level: got drop=%0d level=%0d, required %0d 0",
                     pkt_drop_cnt, buf_level, drop0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        m_axis_tready = 1'b0;
        send_pkt(2, 1'b0);
        send_pkt(2, 1'b0);
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (buf_level !== 5) $display("FAIL midrst_level_before: got %0d, required 5", buf_level);
        else n_pass++;
        rst = 1'b1;
        s_axis_tlast = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tuser} !== '0)
            $display("FAIL midrst_outputs: got valid=%b last=%b data=%h, required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        else n_pass++;
        n_checks++;
        if (pkt_in_cnt !== 0 || pkt_drop_cnt !== 0 || pkt_out_cnt !== 0 || buf_level !== 0)
            $display("FAIL midrst_counters: got in=%0d drop=%0d out=%0d level=%0d, required 0 0 0 0",
                     pkt_in_cnt, pkt_drop_cnt, pkt_out_cnt, buf_level);
        else n_pass++;
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        sb.delete();
        m_axis_tready = 1'b1;
        send_pkt(2, 1'b1);
        wait_drain(50, ok);
        n_checks++;
        if (!ok || pkt_in_cnt !== 1 || pkt_out_cnt !== 1 || pkt_drop_cnt !== 0 || buf_level !== 0)
            $display("FAIL midrst_after: got ok=%b in=%0d out=%0d drop=%0d level=%0d, required 1 1 1 0 0",
                     ok, pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt, buf_level);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_latency();
        test_overflow();
        test_back_to_back();
        test_random_ready();
        test_wrap();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
